// File: rtl/register_file_sb.sv
// Two-write/two-read register file with zero-cycle write bypass and a
// one-bit-per-register scoreboard of pending destination writes.
module register_file_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned ZERO_REG   = 0
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_we0,
  input  logic                        i_we1,
  input  logic [ADDR_WIDTH-1:0]       i_ws0,
  input  logic [ADDR_WIDTH-1:0]       i_ws1,
  input  logic [DATA_WIDTH-1:0]       i_wd0,
  input  logic [DATA_WIDTH-1:0]       i_wd1,
  input  logic [ADDR_WIDTH-1:0]       i_rs1,
  input  logic [ADDR_WIDTH-1:0]       i_rs2,
  output logic [DATA_WIDTH-1:0]       o_rd1,
  output logic [DATA_WIDTH-1:0]       o_rd2,
  input  logic                        i_issue,
  input  logic [ADDR_WIDTH-1:0]       i_issue_rd,
  output logic                        o_busy1,
  output logic                        o_busy2,
  output logic [(2**ADDR_WIDTH)-1:0]  o_busy_vec
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
  localparam bit          ZeroReg  = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  wr0_en, wr1_en;

  // Writes to a hardwired register 0 are dropped before they reach storage.
  assign wr0_en = i_we0 && !(ZeroReg && (i_ws0 == '0));
  assign wr1_en = i_we1 && !(ZeroReg && (i_ws1 == '0));

  // Issue is applied after write-clears so a same-cycle issue leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (i_we0) busy_d[i_ws0] = 1'b0;
    if (i_we1) busy_d[i_ws1] = 1'b0;
    if (i_issue) busy_d[i_issue_rd] = 1'b1;
    if (ZeroReg) busy_d[0] = 1'b0;
  end

  // Port 1 is written last so it wins a same-register collision.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr0_en) regs_q[i_ws0] <= i_wd0;
      if (wr1_en) regs_q[i_ws1] <= i_wd1;
      busy_q <= busy_d;
    end
  end

  logic [ADDR_WIDTH-1:0] rs_sel [2];
  logic [DATA_WIDTH-1:0] rd_val [2];
  logic                  busy_val [2];

  assign rs_sel[0] = i_rs1;
  assign rs_sel[1] = i_rs2;

  for (genvar p = 0; p < 2; p++) begin : g_read
    logic hit0, hit1;
    assign hit0 = i_we0 && (i_ws0 == rs_sel[p]);
    assign hit1 = i_we1 && (i_ws1 == rs_sel[p]);

    always_comb begin
      rd_val[p] = regs_q[rs_sel[p]];
      if (hit0) rd_val[p] = i_wd0;
      if (hit1) rd_val[p] = i_wd1;
      if (ZeroReg && (rs_sel[p] == '0)) rd_val[p] = '0;
    end

    assign busy_val[p] = busy_q[rs_sel[p]] && !(hit0 || hit1);
  end

  assign o_rd1      = rd_val[0];
  assign o_rd2      = rd_val[1];
  assign o_busy1    = busy_val[0];
  assign o_busy2    = busy_val[1];
  assign o_busy_vec = busy_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Randomised scoreboard bench for register_file_sb, run on two instances at
// once: one with a general register 0 and one with register 0 hardwired to zero.
module tb_register_file_sb;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_we0 = 1'b0, i_we1 = 1'b0;
  logic [3:0]  i_ws0 = '0, i_ws1 = '0;
  logic [31:0] i_wd0 = '0, i_wd1 = '0;
  logic [3:0]  i_rs1 = '0, i_rs2 = '0;
  logic        i_issue = 1'b0;
  logic [3:0]  i_issue_rd = '0;

  logic [31:0] rd1_a, rd2_a, rd1_z, rd2_z;
  logic        b1_a, b2_a, b1_z, b2_z;
  logic [15:0] vec_a, vec_z;

  always #5 i_clk = ~i_clk;

  register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(0)) dut_a (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_we0(i_we0), .i_we1(i_we1), .i_ws0(i_ws0), .i_ws1(i_ws1),
    .i_wd0(i_wd0), .i_wd1(i_wd1), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .o_rd1(rd1_a), .o_rd2(rd2_a), .i_issue(i_issue), .i_issue_rd(i_issue_rd),
    .o_busy1(b1_a), .o_busy2(b2_a), .o_busy_vec(vec_a)
  );

  register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(1)) dut_z (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_we0(i_we0), .i_we1(i_we1), .i_ws0(i_ws0), .i_ws1(i_ws1),
    .i_wd0(i_wd0), .i_wd1(i_wd1), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .o_rd1(rd1_z), .o_rd2(rd2_z), .i_issue(i_issue), .i_issue_rd(i_issue_rd),
    .o_busy1(b1_z), .o_busy2(b2_z), .o_busy_vec(vec_z)
  );

  typedef struct packed {
    logic [31:0] rd1a, rd2a;
    logic        b1a, b2a;
    logic [15:0] va;
    logic [31:0] rd1z, rd2z;
    logic        b1z, b2z;
    logic [15:0] vz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: index 0 models ZERO_REG=0, index 1 models ZERO_REG=1.
  logic [31:0] mem  [2][16];
  logic        busy [2][16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_read(input int z, input logic [3:0] rs, output logic [31:0] val,
                            output logic bsy);
    logic hit;
    hit = (i_we0 && i_ws0 == rs) || (i_we1 && i_ws1 == rs);
    if (z == 1 && rs == 0)           val = 32'h0;
    else if (i_we1 && i_ws1 == rs)   val = i_wd1;
    else if (i_we0 && i_ws0 == rs)   val = i_wd0;
    else                             val = mem[z][rs];
    bsy = busy[z][rs] && !hit;
  endtask

  task automatic step(input logic rst,
                      input logic we0, input logic [3:0] ws0, input logic [31:0] wd0,
                      input logic we1, input logic [3:0] ws1, input logic [31:0] wd1,
                      input logic [3:0] rs1, input logic [3:0] rs2,
                      input logic iss, input logic [3:0] ird);
    exp_t e;
    @(posedge i_clk);
    #1;
    i_reset = rst; i_we0 = we0; i_ws0 = ws0; i_wd0 = wd0;
    i_we1 = we1; i_ws1 = ws1; i_wd1 = wd1; i_rs1 = rs1; i_rs2 = rs2;
    i_issue = iss; i_issue_rd = ird;
    model_read(0, rs1, e.rd1a, e.b1a);
    model_read(0, rs2, e.rd2a, e.b2a);
    model_read(1, rs1, e.rd1z, e.b1z);
    model_read(1, rs2, e.rd2z, e.b2z);
    for (int r = 0; r < 16; r++) begin
      e.va[r] = busy[0][r];
      e.vz[r] = busy[1][r];
    end
    exp_q.push_back(e);
    // State as it will be after the coming edge.
    for (int z = 0; z < 2; z++) begin
      if (rst) begin
        for (int r = 0; r < 16; r++) begin
          mem[z][r] = 32'h0;
          busy[z][r] = 1'b0;
        end
      end else begin
        if (we0 && !(z == 1 && ws0 == 0)) mem[z][ws0] = wd0;
        if (we1 && !(z == 1 && ws1 == 0)) mem[z][ws1] = wd1;
        if (we0) busy[z][ws0] = 1'b0;
        if (we1) busy[z][ws1] = 1'b0;
        if (iss && !(z == 1 && ird == 0)) busy[z][ird] = 1'b1;
      end
    end
  endtask

  task automatic rd(input logic [3:0] rs1, input logic [3:0] rs2);
    step(0, 0, 0, 0, 0, 0, 0, rs1, rs2, 0, 0);
  endtask

  // Monitor: compares every sampled cycle that has a pending expectation.
  always @(negedge i_clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rd1_a", rd1_a, e.rd1a);
      chk("rd2_a", rd2_a, e.rd2a);
      chk("busy1_a", {31'h0, b1_a}, {31'h0, e.b1a});
      chk("busy2_a", {31'h0, b2_a}, {31'h0, e.b2a});
      chk("busy_vec_a", {16'h0, vec_a}, {16'h0, e.va});
      chk("rd1_z", rd1_z, e.rd1z);
      chk("rd2_z", rd2_z, e.rd2z);
      chk("busy1_z", {31'h0, b1_z}, {31'h0, e.b1z});
      chk("busy2_z", {31'h0, b2_z}, {31'h0, e.b2z});
      chk("busy_vec_z", {16'h0, vec_z}, {16'h0, e.vz});
    end
  end

  initial begin
    for (int z = 0; z < 2; z++)
      for (int r = 0; r < 16; r++) begin
        mem[z][r] = 32'h0;
        busy[z][r] = 1'b0;
      end
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;

    // Reset state, then same-cycle bypass and retained value.
    rd(4'd3, 4'd0);
    step(0, 1, 4'd3, 32'hDEADBEEF, 0, 0, 0, 4'd3, 4'd1, 0, 0);
    rd(4'd3, 4'd3);
    // Same-register write collision: port 1 wins.
    step(0, 1, 4'd5, 32'h11, 1, 4'd5, 32'h22, 4'd5, 4'd5, 0, 0);
    rd(4'd5, 4'd3);
    // Issue, busy visible, write releases with bypass.
    step(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd7, 1, 4'd7);
    rd(4'd0, 4'd7);
    step(0, 0, 0, 0, 1, 4'd7, 32'h55, 4'd0, 4'd7, 0, 0);
    rd(4'd7, 4'd7);
    // Issue and write to the same register in one cycle keeps it busy.
    step(0, 0, 0, 0, 0, 0, 0, 4'd9, 4'd0, 1, 4'd9);
    step(0, 1, 4'd9, 32'h99, 0, 0, 0, 4'd9, 4'd0, 1, 4'd9);
    rd(4'd9, 4'd9);
    // Register 0 write and issue.
    step(0, 1, 4'd0, 32'hFF, 0, 0, 0, 4'd0, 4'd0, 1, 4'd0);
    rd(4'd0, 4'd0);
    // Mid-operation reset clears data and pending busy bits.
    step(0, 1, 4'd2, 32'hA5A5, 1, 4'd4, 32'h5A5A, 4'd2, 4'd4, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 4'd2, 4'd4, 1, 4'd2);
    step(0, 0, 0, 0, 0, 0, 0, 4'd2, 4'd4, 1, 4'd4);
    step(1, 1, 4'd6, 32'h1234, 0, 0, 0, 4'd2, 4'd4, 1, 4'd6);
    rd(4'd2, 4'd4);
    rd(4'd6, 4'd9);

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
    end
    rd(4'd0, 4'd1);

    repeat (3) @(negedge i_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each register and of all data ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: register selector width; register count NUM_REGS = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter ZERO_REG, default 0: when 1, register 0 is hardwired to zero.
REQ-004 SHALL have port i_clk, input, 1: the block's single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have ports i_we0 / i_we1, input, 1: write enables, write port 0 and write port 1.
REQ-007 SHALL have ports i_ws0 / i_ws1, input, ADDR_WIDTH: write register selectors.
REQ-008 SHALL have ports i_wd0 / i_wd1, input, DATA_WIDTH: write data.
REQ-009 SHALL have ports i_rs1 / i_rs2, input, ADDR_WIDTH: read register selectors.
REQ-010 SHALL have ports o_rd1 / o_rd2, output, DATA_WIDTH: read data.
REQ-011 SHALL have port i_issue, input, 1: an instruction with a pending destination register is issued this cycle.
REQ-012 SHALL have port i_issue_rd, input, ADDR_WIDTH: destination register of the issued instruction.
REQ-013 SHALL have ports o_busy1 / o_busy2, output, 1: the read operand has a pending write and is not being bypassed this cycle.
REQ-014 SHALL have port o_busy_vec, output, NUM_REGS: current scoreboard contents, one bit per register.

Function
REQ-015 Writes SHALL commit at the rising edge of i_clk: a register takes i_wdN when i_weN=1 and i_wsN selects it.
REQ-016 When both write ports target the same register in the same cycle, port 1 SHALL win.
REQ-017 Reads SHALL be combinational, with zero-cycle bypass: o_rdX = i_wd1 if i_we1 and i_ws1==i_rsX; otherwise i_wd0 if i_we0 and i_ws0==i_rsX; otherwise the stored value.
REQ-018 With ZERO_REG=1, reads of register 0 SHALL return 0, including under bypass.
REQ-019 With ZERO_REG=1, writes to register 0 SHALL be ignored and register 0 SHALL never become busy.
REQ-020 Scoreboard: each register SHALL have a busy bit, set at the clock edge when i_issue=1 and i_issue_rd selects it.
REQ-021 A busy bit SHALL clear at the clock edge when either write port writes that register.
REQ-022 When issue and write target the same register in one cycle, the busy bit SHALL end set (the new pending write takes precedence).
REQ-023 An issue to an already-busy register SHALL leave it busy; there is a single bit per register and no pending-write count.
REQ-024 o_busyX SHALL equal busy[i_rsX] AND NOT (any write port enabled with a selector equal to i_rsX) in the same cycle.
REQ-025 i_issue SHALL NOT affect o_busy1 / o_busy2 or o_rd1 / o_rd2 in the cycle it is asserted.
REQ-026 o_busy_vec SHALL reflect registered busy state only, with no bypass term.
REQ-027 Selectors SHALL cover all NUM_REGS registers with no out-of-range case.

Reset
REQ-028 While i_reset=1 at a clock edge, all registers and all busy bits SHALL become 0, and writes and issues that cycle SHALL be discarded.
REQ-029 After reset, o_rd1 = o_rd2 = 0, o_busy1 = o_busy2 = 0 and o_busy_vec = 0 until the first write or issue, ignoring bypass from inputs asserted in the same cycle.
REQ-030 Reset asserted mid-operation SHALL clear all pending busy bits; no write is required to release them.

Verification
REQ-031 Reset, then i_we0=1, i_ws0=3, i_wd0=0xDEADBEEF, i_rs1=3 -> o_rd1=0xDEADBEEF in the same cycle (bypass); after deasserting i_we0, o_rd1 stays 0xDEADBEEF.
REQ-032 In one cycle, i_we0=1 with i_ws0=5, i_wd0=0x11 and i_we1=1 with i_ws1=5, i_wd1=0x22 -> o_rd1=0x22 (i_rs1=5) that cycle, and register 5 holds 0x22 afterwards.
REQ-033 i_issue=1, i_issue_rd=7 for one cycle; next cycle with i_rs2=7 -> o_busy2=1, o_busy_vec[7]=1; then i_we1=1, i_ws1=7, i_wd1=0x55 -> o_busy2=0 and o_rd2=0x55 that cycle, and busy[7]=0 after the edge.
REQ-034 Register 9 busy; i_issue_rd=9 together with i_we0=1, i_ws0=9 in one cycle -> busy[9] remains 1 after the edge.
REQ-035 ZERO_REG=1: i_we0=1, i_ws0=0, i_wd0=0xFF and i_issue_rd=0 -> o_rd1=0 (i_rs1=0) that cycle and afterwards, and o_busy_vec[0] stays 0.
REQ-036 Registers 2 and 4 busy with data nonzero; assert i_reset for one cycle -> o_busy_vec=0, all reads return 0.
